// File: rtl/rp_trig_pkg.sv
// rp_trig_pkg: shared state encodings, trigger codes and default sizes for the trigger controller.
package rp_trig_pkg;
   localparam int NSRC_DEF = 4;
   localparam int CW_DEF = 32;
   localparam logic [3:0] SRC_NONE = 4'h0;
   localparam logic [3:0] SRC_SW = 4'hF;
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_WAIT = 3'd2,
      ST_POST = 3'd3,
      ST_HOLD = 3'd4
   } state_t;
endpackage

// File: rtl/rp_trig_src_sel.sv
// rp_trig_src_sel: decodes the selected hardware source, gives software priority and forms the trigger code.
module rp_trig_src_sel import rp_trig_pkg::*; #(
   parameter int NSRC = NSRC_DEF
) (
   input  logic [NSRC-1:0] trig_src,
   input  logic [3:0]      src_sel,
   input  logic            sw_trig,
   output logic            evt,
   output logic [3:0]      code
);
   logic hw;
   // Out-of-range selects match no bit and so never fire.
   always_comb begin
      hw = 1'b0;
      for (int i = 0; i < NSRC; i++) hw = hw | (trig_src[i] & (src_sel == 4'(i + 1)));
   end
   assign evt = sw_trig | hw;
   assign code = sw_trig ? SRC_SW : src_sel;
endmodule

// File: rtl/rp_trig_ctrl.sv
// rp_trig_ctrl: arm / pre-trigger / wait / post-trigger / holdoff sequencer for the ADC acquisition trigger.
module rp_trig_ctrl import rp_trig_pkg::*; #(
   parameter int NSRC = NSRC_DEF,
   parameter int CW   = CW_DEF
) (
   input  logic            adc_clk_i,
   input  logic            adc_rstn_i,
   input  logic            adc_dv_i,
   input  logic [NSRC-1:0] trig_src_i,
   input  logic [3:0]      src_sel_i,
   input  logic            sw_trig_i,
   input  logic            arm_i,
   input  logic            abort_i,
   input  logic            auto_i,
   input  logic [CW-1:0]   pre_dly_i,
   input  logic [CW-1:0]   post_dly_i,
   input  logic [CW-1:0]   holdoff_i,
   output logic            trig_o,
   output logic            done_o,
   output logic            armed_o,
   output logic            wait_o,
   output logic [3:0]      trig_code_o,
   output logic [2:0]      state_o
);
   state_t state, nxt;
   logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
   logic evt, trig_nxt, done_nxt, armed_nxt, wait_nxt;
   logic [3:0] code, code_nxt;

   rp_trig_src_sel #(.NSRC(NSRC)) u_src_sel (
      .trig_src(trig_src_i),
      .src_sel (src_sel_i),
      .sw_trig (sw_trig_i),
      .evt     (evt),
      .code    (code)
   );

   assign cnt_inc = (&cnt) ? cnt : cnt + CW'(1);
   assign state_o = state;

   always_ff @(posedge adc_clk_i or negedge adc_rstn_i)
      if (!adc_rstn_i) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         trig_o      <= 1'b0;
         done_o      <= 1'b0;
         armed_o     <= 1'b0;
         wait_o      <= 1'b0;
         trig_code_o <= SRC_NONE;
      end else begin
         state       <= nxt;
         cnt         <= cnt_nxt;
         trig_o      <= trig_nxt;
         done_o      <= done_nxt;
         armed_o     <= armed_nxt;
         wait_o      <= wait_nxt;
         trig_code_o <= code_nxt;
      end

   // Every state exit clears the counter so each phase starts from zero.
   always_comb begin
      nxt = state;
      cnt_nxt = cnt;
      case (state)
         ST_IDLE: if (arm_i) begin nxt = ST_PRE; cnt_nxt = '0; end
         ST_PRE:  if (cnt >= pre_dly_i) begin nxt = ST_WAIT; cnt_nxt = '0; end else if (adc_dv_i) cnt_nxt = cnt_inc;
         ST_WAIT: if (evt) begin nxt = ST_POST; cnt_nxt = '0; end
         ST_POST: if (cnt >= post_dly_i) begin nxt = ST_HOLD; cnt_nxt = '0; end else if (adc_dv_i) cnt_nxt = cnt_inc;
         ST_HOLD: if (cnt >= holdoff_i) begin nxt = auto_i ? ST_PRE : ST_IDLE; cnt_nxt = '0; end else cnt_nxt = cnt_inc;
         default: begin nxt = ST_IDLE; cnt_nxt = '0; end
      endcase
      if (abort_i) begin nxt = ST_IDLE; cnt_nxt = '0; end
   end

   always_comb begin
      trig_nxt  = !abort_i && state == ST_WAIT && evt;
      done_nxt  = !abort_i && state == ST_POST && cnt >= post_dly_i;
      code_nxt  = trig_nxt ? code : trig_code_o;
      armed_nxt = nxt == ST_PRE || nxt == ST_WAIT || nxt == ST_POST;
      wait_nxt  = nxt == ST_WAIT;
   end
endmodule

// File: tb/tb_rp_trig_ctrl.sv
// tb_rp_trig_ctrl: directed scenarios with a queue of expected trig/done pulses checked every cycle.
module tb_rp_trig_ctrl;
   import rp_trig_pkg::*;
   localparam int NSRC = 4;
   localparam int CW = 32;
   logic clk = 0, rstn = 0, dv = 1, sw = 0, arm = 0, abort = 0, auto_re = 0;
   logic [NSRC-1:0] src = '0;
   logic [3:0] sel = 4'd1;
   logic [CW-1:0] pre = 4, post = 3, hold = 2;
   logic trig, done, armed, waiting;
   logic [3:0] code;
   logic [2:0] st;
   logic [2:0] seq [4];
   int n_chk = 0, n_fail = 0, cyc = 0;
   bit dv_half = 0;
   typedef struct {bit kind; int lo; int hi; logic [3:0] code; string tag;} ev_t;
   ev_t q[$];

   rp_trig_ctrl #(.NSRC(NSRC), .CW(CW)) dut (
      .adc_clk_i  (clk),
      .adc_rstn_i (rstn),
      .adc_dv_i   (dv),
      .trig_src_i (src),
      .src_sel_i  (sel),
      .sw_trig_i  (sw),
      .arm_i      (arm),
      .abort_i    (abort),
      .auto_i     (auto_re),
      .pre_dly_i  (pre),
      .post_dly_i (post),
      .holdoff_i  (hold),
      .trig_o     (trig),
      .done_o     (done),
      .armed_o    (armed),
      .wait_o     (waiting),
      .trig_code_o(code),
      .state_o    (st)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input bit kind, input int lo, input int hi, input logic [3:0] c, input string tag);
      ev_t e;
      e.kind = kind; e.lo = lo; e.hi = hi; e.code = c; e.tag = tag;
      q.push_back(e);
   endtask

   // Every trig/done pulse must match the queue head in kind and cycle window.
   task automatic mon();
      logic [1:0] ev;
      ev = {done, trig};
      for (int k = 0; k < 2; k++)
         if (ev[k]) begin
            if (q.size() == 0 || q[0].kind != k[0]) chk(k ? "unexp_done" : "unexp_trig", {31'd0, ev[k]}, 0);
            else begin
               chk(q[0].tag, {31'd0, (cyc >= q[0].lo && cyc <= q[0].hi)}, 1);
               if (k == 0) chk({q[0].tag, "_code"}, {28'd0, code}, {28'd0, q[0].code});
               void'(q.pop_front());
            end
         end
      if (q.size() > 0 && cyc > q[0].hi) begin
         chk({q[0].tag, "_missing"}, cyc, q[0].hi);
         void'(q.pop_front());
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (dv_half) dv = ~dv;
      mon();
   endtask

   task automatic wait_state(input logic [2:0] s, input int lim, input string tag);
      int n;
      n = 0;
      while (st !== s && n < lim) begin
         tick();
         n++;
      end
      chk(tag, st, s);
   endtask

   initial begin
      int n, s, p;
      seq = '{ST_PRE, ST_WAIT, ST_POST, ST_HOLD};
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", st, ST_IDLE);
      chk("rst_trig", trig, 0);
      chk("rst_done", done, 0);
      chk("rst_armed", armed, 0);
      chk("rst_wait", waiting, 0);
      chk("rst_code", code, 0);
      rstn = 1;
      tick();
      // basic hardware trigger, pulse during PRE must be ignored
      arm = 1; tick(); arm = 0;
      chk("a_pre", st, ST_PRE);
      chk("a_armed", armed, 1);
      src = 4'b0001; tick(); src = '0;
      repeat (4) tick();
      chk("a_wait", st, ST_WAIT);
      chk("a_wait_o", waiting, 1);
      push(0, cyc + 1, cyc + 1, 4'd1, "a_trig");
      push(1, cyc + 5, cyc + 5, 4'd1, "a_done");
      src = 4'b0001; tick(); src = '0;
      chk("a_post", st, ST_POST);
      chk("a_post_wait_o", waiting, 0);
      repeat (6) tick();
      chk("a_hold", st, ST_HOLD);
      tick();
      chk("a_idle", st, ST_IDLE);
      chk("a_code", code, 4'd1);
      chk("a_q_empty", q.size(), 0);
      // half-rate sample valid
      dv_half = 1;
      arm = 1; tick(); arm = 0;
      n = 0;
      while (st === ST_PRE && n < 20) begin n++; tick(); end
      chk("b_pre_len", {31'd0, (n >= 8 && n <= 9)}, 1);
      chk("b_wait", st, ST_WAIT);
      p = cyc + 1;
      push(0, p, p, 4'd1, "b_trig");
      push(1, p + 6, p + 7, 4'd1, "b_done");
      src = 4'b0001; tick(); src = '0;
      n = 0;
      while (st === ST_POST && n < 20) begin n++; tick(); end
      chk("b_post_len", {31'd0, (n >= 6 && n <= 7)}, 1);
      wait_state(ST_IDLE, 20, "b_idle");
      dv_half = 0; dv = 1;
      // software beats hardware; pulses outside WAIT are not queued
      pre = 0; post = 0; hold = 0; sel = 4'd2;
      arm = 1; tick(); arm = 0;
      chk("c_pre", st, ST_PRE);
      sw = 1; tick(); sw = 0;
      chk("c_wait", st, ST_WAIT);
      tick();
      chk("c_no_queue", st, ST_WAIT);
      push(0, cyc + 1, cyc + 1, SRC_SW, "c_trig");
      push(1, cyc + 2, cyc + 2, SRC_SW, "c_done");
      sw = 1; src = 4'b0010; tick(); sw = 0; src = '0;
      chk("c_post", st, ST_POST);
      tick();
      chk("c_hold", st, ST_HOLD);
      tick();
      chk("c_idle", st, ST_IDLE);
      chk("c_code", code, SRC_SW);
      repeat (2) tick();
      chk("c_q_empty", q.size(), 0);
      // abort in POST, then abort racing a trigger in WAIT
      sel = 4'd1; post = 3;
      arm = 1; tick(); arm = 0; tick();
      chk("d_wait", st, ST_WAIT);
      push(0, cyc + 1, cyc + 1, 4'd1, "d_trig");
      src = 4'b0001; tick(); src = '0;
      chk("d_post", st, ST_POST);
      abort = 1; tick(); abort = 0;
      chk("d_abort_idle", st, ST_IDLE);
      chk("d_abort_armed", armed, 0);
      chk("d_abort_done", done, 0);
      repeat (5) tick();
      arm = 1; tick(); arm = 0; tick();
      chk("d_wait2", st, ST_WAIT);
      arm = 1; tick(); arm = 0;
      chk("d_arm_ignored", st, ST_WAIT);
      abort = 1; sw = 1; src = 4'b0001; tick(); abort = 0; sw = 0; src = '0;
      chk("d_abort2_idle", st, ST_IDLE);
      chk("d_abort2_trig", trig, 0);
      chk("d_abort2_code", code, 4'd1);
      repeat (3) tick();
      chk("d_q_empty", q.size(), 0);
      // auto re-arm with zero delays and a held software trigger
      post = 0; auto_re = 1; sw = 1;
      s = cyc;
      for (int k = 0; k < 4; k++) begin
         push(0, s + 3 + 4 * k, s + 3 + 4 * k, SRC_SW, "e_trig");
         push(1, s + 4 + 4 * k, s + 4 + 4 * k, SRC_SW, "e_done");
      end
      arm = 1; tick(); arm = 0;
      for (int j = 0; j < 16; j++) begin
         chk("e_seq", st, seq[j % 4]);
         if (j < 15) tick();
      end
      sw = 0; abort = 1; tick(); abort = 0; auto_re = 0;
      chk("e_idle", st, ST_IDLE);
      repeat (3) tick();
      chk("e_q_empty", q.size(), 0);
      // invalid select never fires; asynchronous reset while waiting
      sel = 4'd9; src = '1;
      arm = 1; tick(); arm = 0;
      repeat (4) tick();
      chk("f_wait", st, ST_WAIT);
      chk("f_trig", trig, 0);
      #2;
      rstn = 0;
      #1;
      chk("f_rst_state", st, ST_IDLE);
      chk("f_rst_armed", armed, 0);
      chk("f_rst_wait", waiting, 0);
      chk("f_rst_trig", trig, 0);
      chk("f_rst_done", done, 0);
      chk("f_rst_code", code, 0);
      src = '0; sel = 4'd1;
      repeat (2) tick();
      rstn = 1;
      src = 4'b0001; sw = 1;
      repeat (4) tick();
      src = '0; sw = 0;
      chk("f_needs_arm", st, ST_IDLE);
      chk("f_armed_after", armed, 0);
      chk("f_q_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
